soc_system_key_pio: RTL and testbench
=====================================

SOC_SYSTEM_KEY_PIO -- requirements
Module: soc_system_key_pio

Interface
REQ-001 SHALL have parameter: WIDTH, 3, number of key input bits.
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new key level (1 ms at 50 MHz).
REQ-003 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: address  input  2  Avalon-MM word address.
REQ-006 SHALL have port: chipselect  input  1  slave select.
REQ-007 SHALL have port: write_n  input  1  active-low write strobe.
REQ-008 SHALL have port: writedata  input  32  write data.
REQ-009 SHALL have port: in_port  input  WIDTH  asynchronous key inputs, active-low (pressed = 0).
REQ-010 SHALL have port: readdata  output  32  read data, zero wait states.
REQ-011 SHALL have port: irq  output  1  level interrupt, active-high.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer per bit before any other use.
REQ-013 SHALL hold a debounced key vector key_db; without debounce it equals the synchronized value.
REQ-014 SHALL set edge_capture[i] in the cycle after key_db[i] transitions 1->0 (falling edge = press); rising edges are ignored.
REQ-015 SHALL implement register map: addr 0 data (RO, key_db), addr 1 reserved (reads 0, writes ignored), addr 2 irq_mask (RW), addr 3 edge_capture (RO, write-1-to-clear).
REQ-016 SHALL drive readdata combinationally from address, registered values zero-extended to 32 bits; read has no side effects.
REQ-017 SHALL update irq_mask on chipselect && !write_n && address==2 with writedata[WIDTH-1:0].
REQ-018 SHALL clear edge_capture bits whose writedata bit is 1 on chipselect && !write_n && address==3.
REQ-019 SHALL give set priority: a new falling edge in the same cycle as a write-1-to-clear leaves that bit 1.
REQ-020 SHALL drive irq = |(edge_capture & irq_mask), from registers only, no combinational path from bus inputs.
REQ-021 SHALL ignore writedata bits [31:WIDTH] and writes to addr 0 and 1.

Reset
REQ-022 SHALL reset synchronizer flops and key_db to all ones (released), so no edge is captured on reset exit.
REQ-023 SHALL reset edge_capture, irq_mask, debounce counters to 0; irq and readdata-backing state therefore 0 except data reads all ones.
REQ-024 SHALL abort any in-progress debounce count on reset assertion, mid-count included.

Configuration
REQ-025 SHALL compile debounce in only when macro SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN is defined.
REQ-026 With SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN: per bit, counter increments while synchronized != key_db, clears when equal; key_db[i] takes the synchronized value when counter reaches DEBOUNCE_CYCLES-1, counter then clears; counter width ceil(log2(DEBOUNCE_CYCLES)), saturates never wrapping.
REQ-027 Without SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN: key_db = synchronized value, no counters, DEBOUNCE_CYCLES unused.

Structure
REQ-028 SHALL place register offsets (DATA=0, IRQ_MASK=2, EDGE_CAP=3) and default WIDTH in shared package soc_system_pio_pkg.
REQ-029 SHALL implement per-bit debounce in sub-module soc_system_key_debounce, instantiated WIDTH times under the macro.

Verification
REQ-030 Reset release with in_port=3'b111 -> read addr0 = 0x7, addr3 = 0x0, irq=0.
REQ-031 No debounce: in_port[1] 1->0 -> addr3 reads 0x2 within 4 cycles; write 0x2 to addr2 -> irq=1; write 0x2 to addr3 -> addr3=0, irq=0.
REQ-032 Debounce, DEBOUNCE_CYCLES=8: in_port[0] glitch low 5 cycles -> addr0 stays 0x7, addr3=0; low 20 cycles -> addr0=0x6, addr3=0x1.
REQ-033 Simultaneous: falling edge on bit2 in same cycle as write 0x4 to addr3 -> addr3 reads 0x4.
REQ-034 Release (0->1) on bit0 with mask 0x7 -> addr3 unchanged, irq unchanged.
REQ-035 Assert reset_n low mid-debounce count -> after release addr0=0x7, addr2=0, addr3=0, irq=0.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the SoC key PIO: Avalon register offsets and the
// default key-vector width.
package soc_system_pio_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RSVD     = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } pio_addr_e;

endpackage

// File: rtl/soc_system_key_debounce.sv
// Single-bit key debouncer. A new level is accepted only after it has been
// stable for DEBOUNCE_CYCLES consecutive clocks. Built only when
// SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN is defined; otherwise this file is empty.
`ifdef SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN
module soc_system_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic key_db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Count while the input disagrees with the accepted level; the count is
  // cleared at CNT_LAST, so it can never run past it and wrap.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_in == db_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      db_d  = sync_in;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Key released (1) out of reset; any count in progress is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign key_db = db_q;

endmodule
`endif

// File: rtl/soc_system_key_pio.sv
// Avalon-MM key PIO: synchronizes active-low key inputs, optionally debounces
// them (macro SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN), latches press (falling) edges
// and raises a masked level interrupt.
module soc_system_key_pio
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] key_db;
  logic [WIDTH-1:0] key_db_dly_q, key_db_dly_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr_bits;
  logic             bus_wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:WIDTH];

  // Two-flop synchronizer per key bit.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Synchronizer resets to released so reset exit produces no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    soc_system_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .sync_in(sync2_q[i]),
      .key_db (key_db[i])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign key_db = sync2_q;
`endif

  // Bus writes, press-edge capture (set beats clear) and mask update.
  always_comb begin
    bus_wr       = chipselect && !write_n;
    key_db_dly_d = key_db;
    fall         = key_db_dly_q & ~key_db;
    clr_bits     = (bus_wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    edge_cap_d   = (edge_cap_q & ~clr_bits) | fall;
    irq_mask_d   = (bus_wr && address == ADDR_IRQ_MASK) ? writedata[WIDTH-1:0] : irq_mask_q;
  end

  // Edge-detect history starts released; capture and mask start cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db_dly_q <= '1;
      edge_cap_q   <= '0;
      irq_mask_q   <= '0;
    end else begin
      key_db_dly_q <= key_db_dly_d;
      edge_cap_q   <= edge_cap_d;
      irq_mask_q   <= irq_mask_d;
    end
  end

  // Zero-wait-state read mux; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(key_db);
      ADDR_IRQ_MASK: readdata = 32'(irq_mask_q);
      ADDR_EDGE_CAP: readdata = 32'(edge_cap_q);
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_key_pio.sv
// Directed bench for soc_system_key_pio; adapts edge latency when
// SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN is defined (DEBOUNCE_CYCLES = 8).
module tb_soc_system_key_pio;

  localparam int WIDTH = 3;
  localparam int DEB   = 8;
`ifdef SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN
  localparam int EDGE_LAT = 3 + DEB;
`else
  localparam int EDGE_LAT = 3;
`endif
  localparam int SETTLE = EDGE_LAT + 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int tests_run = 0;
  int tests_failed = 0;

  soc_system_key_pio #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; in_port = 3'b111; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    wait_neg(3);
    reset_n = 1'b1;
    wait_neg(2);
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h7) begin tests_failed++; $display("FAIL reset_data got %h exp %h", d, 32'h7); end
    read_reg(2'd1, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_rsvd got %h exp %h", d, 32'h0); end
    read_reg(2'd2, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_mask got %h exp %h", d, 32'h0); end
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_edge got %h exp %h", d, 32'h0); end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got %b exp 0", irq); end
  endtask

  task automatic test_press_irq();
    logic [31:0] d;
    @(negedge clk); in_port = 3'b101;
    wait_neg(SETTLE);
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL press_edge got %h exp %h", d, 32'h2); end
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h5) begin tests_failed++; $display("FAIL press_data got %h exp %h", d, 32'h5); end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL press_irq_masked got %b exp 0", irq); end
    write_reg(2'd2, 32'h2);
    read_reg(2'd2, d); tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL mask_read got %h exp %h", d, 32'h2); end
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL press_irq got %b exp 1", irq); end
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("FAIL read_no_side_effect got %h exp %h", d, 32'h2); end
    write_reg(2'd3, 32'h2);
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL w1c_edge got %h exp %h", d, 32'h0); end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL w1c_irq got %b exp 0", irq); end
    @(negedge clk); in_port = 3'b111;
    wait_neg(SETTLE);
  endtask

  task automatic test_write_ignore();
    logic [31:0] d;
    write_reg(2'd0, 32'hFFFF_FFFF);
    write_reg(2'd1, 32'hFFFF_FFFF);
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h7) begin tests_failed++; $display("FAIL wr_addr0_ignored got %h exp %h", d, 32'h7); end
    read_reg(2'd1, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL wr_addr1_ignored got %h exp %h", d, 32'h0); end
    write_reg(2'd2, 32'hFFFF_FFF8);
    read_reg(2'd2, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL mask_upper_ignored got %h exp %h", d, 32'h0); end
    write_reg(2'd2, 32'h7);
    read_reg(2'd2, d); tests_run++;
    if (d !== 32'h7) begin tests_failed++; $display("FAIL mask_all got %h exp %h", d, 32'h7); end
  endtask

  task automatic test_release();
    logic [31:0] d;
    @(negedge clk); in_port = 3'b110;
    wait_neg(SETTLE);
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL rel_pre_edge got %h exp %h", d, 32'h1); end
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL rel_pre_irq got %b exp 1", irq); end
    @(negedge clk); in_port = 3'b111;
    wait_neg(SETTLE);
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL rel_edge got %h exp %h", d, 32'h1); end
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL rel_irq got %b exp 1", irq); end
    write_reg(2'd3, 32'h7);
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL rel_clear got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    @(negedge clk); in_port = 3'b011;
    wait_neg(EDGE_LAT - 1);
    // Write is sampled on the same rising edge that captures the press.
    address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h4) begin tests_failed++; $display("FAIL set_priority got %h exp %h", d, 32'h4); end
    @(negedge clk); in_port = 3'b111;
    wait_neg(SETTLE);
    write_reg(2'd3, 32'h7);
  endtask

`ifdef SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d;
    @(negedge clk); in_port = 3'b110;
    wait_neg(5);
    in_port = 3'b111;
    wait_neg(SETTLE);
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h7) begin tests_failed++; $display("FAIL glitch_data got %h exp %h", d, 32'h7); end
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL glitch_edge got %h exp %h", d, 32'h0); end
    @(negedge clk); in_port = 3'b110;
    wait_neg(20);
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h6) begin tests_failed++; $display("FAIL stable_data got %h exp %h", d, 32'h6); end
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL stable_edge got %h exp %h", d, 32'h1); end
    @(negedge clk); in_port = 3'b111;
    wait_neg(SETTLE);
    write_reg(2'd3, 32'h7);
  endtask
`else
  task automatic test_short_pulse();
    logic [31:0] d;
    @(negedge clk); in_port = 3'b110;
    wait_neg(2);
    in_port = 3'b111;
    wait_neg(SETTLE);
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL pulse_edge got %h exp %h", d, 32'h1); end
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h7) begin tests_failed++; $display("FAIL pulse_data got %h exp %h", d, 32'h7); end
    write_reg(2'd3, 32'h7);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    write_reg(2'd2, 32'h7);
    @(negedge clk); in_port = 3'b101;
    wait_neg(EDGE_LAT - 1);
    #2 reset_n = 1'b0;
    @(negedge clk); in_port = 3'b111;
    wait_neg(3);
    reset_n = 1'b1;
    wait_neg(SETTLE);
    read_reg(2'd0, d); tests_run++;
    if (d !== 32'h7) begin tests_failed++; $display("FAIL rstmid_data got %h exp %h", d, 32'h7); end
    read_reg(2'd2, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL rstmid_mask got %h exp %h", d, 32'h0); end
    read_reg(2'd3, d); tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL rstmid_edge got %h exp %h", d, 32'h0); end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL rstmid_irq got %b exp 0", irq); end
  endtask

  initial begin
    test_reset();
    test_press_irq();
    test_write_ignore();
    test_release();
    test_simultaneous();
`ifdef SOC_SYSTEM_KEY_PIO_DEBOUNCE_EN
    test_debounce();
`else
    test_short_pulse();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
